// File: rtl/conv_window_buffer.sv
// Streaming KxK binary patch extractor: line memories plus a shift window, with runtime
// kernel size, stride and image size, and valid/ready on both pixel input and patch output.
module conv_window_buffer #(
  parameter int unsigned BUF_WIDTH       = 34,
  parameter int unsigned BUF_HEIGHT      = 34,
  parameter int unsigned MAX_KERNEL_SIZE = 7,
  parameter int unsigned NUM_CH          = 1
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic                                           start,
  input  logic [$clog2(BUF_WIDTH+1)-1:0]                 img_width,
  input  logic [$clog2(BUF_HEIGHT+1)-1:0]                img_height,
  input  logic [$clog2(MAX_KERNEL_SIZE+1)-1:0]           kernel_size,
  input  logic [1:0]                                     stride,
  input  logic [NUM_CH-1:0]                              pix_in,
  input  logic                                           pix_valid,
  output logic                                           pix_ready,
  output logic [MAX_KERNEL_SIZE*MAX_KERNEL_SIZE*NUM_CH-1:0] patch_out,
  output logic                                           patch_valid,
  input  logic                                           patch_ready,
  output logic [$clog2(BUF_WIDTH)-1:0]                   patch_x,
  output logic [$clog2(BUF_HEIGHT)-1:0]                  patch_y,
  output logic                                           busy,
  output logic                                           frame_done,
  output logic                                           cfg_err
);

  localparam int unsigned MK = MAX_KERNEL_SIZE;
  localparam int unsigned WW = $clog2(BUF_WIDTH + 1);
  localparam int unsigned HW = $clog2(BUF_HEIGHT + 1);
  localparam int unsigned KW = $clog2(MK + 1);
  localparam int unsigned XW = $clog2(BUF_WIDTH);
  localparam int unsigned YW = $clog2(BUF_HEIGHT);
  localparam int unsigned CW = WW + 1;
  localparam int unsigned RW = HW + 1;
  localparam int unsigned NL = MK - 1;
  localparam int unsigned LW = (NL > 1) ? $clog2(NL) : 1;

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

  state_t            state;
  logic [WW-1:0]     wcfg;
  logic [HW-1:0]     hcfg;
  logic [KW-1:0]     kcfg;
  logic [1:0]        scfg;
  logic [XW-1:0]     col;
  logic [YW-1:0]     row;
  logic [1:0]        cph;
  logic [1:0]        rph;

  logic [NUM_CH-1:0] win      [MK][MK];
  logic [NUM_CH-1:0] win_nxt  [MK][MK];
  logic [NUM_CH-1:0] line_mem [NL][BUF_WIDTH];
  logic [NUM_CH-1:0] line_rd  [NL];
  logic [NUM_CH-1:0] new_col  [MK];

  logic accept;
  logic emit;
  logic col_last;
  logic row_last;
  logic col_in;
  logic row_in;
  logic cfg_ok;

  // Phase counters track (pos-K+1) mod S so no divider is needed.
  function automatic logic [1:0] ph_step(input logic [1:0] ph, input logic [1:0] s);
    ph_step = (ph + 2'd1 == s) ? 2'd0 : ph + 2'd1;
  endfunction

  assign pix_ready = (state == STREAM) && (!patch_valid || patch_ready);
  assign accept    = pix_valid && pix_ready;
  assign col_last  = (CW'(col) + CW'(1)) == CW'(wcfg);
  assign row_last  = (RW'(row) + RW'(1)) == RW'(hcfg);
  assign col_in    = (CW'(col) + CW'(1)) >= CW'(kcfg);
  assign row_in    = (RW'(row) + RW'(1)) >= RW'(kcfg);
  assign emit      = col_in && row_in && (cph == 2'd0) && (rph == 2'd0);

  assign cfg_ok = (kernel_size != '0) && (kernel_size <= KW'(MK))
               && (CW'(img_width) >= CW'(kernel_size)) && (CW'(img_width) <= CW'(BUF_WIDTH))
               && (RW'(img_height) >= RW'(kernel_size)) && (RW'(img_height) <= RW'(BUF_HEIGHT))
               && (stride != 2'd0);

  always_comb begin
    for (int i = 0; i < NL; i++) line_rd[i] = line_mem[i][col];
  end

  // Incoming column: current pixel at row K-1, older lines above it, zeros below K.
  always_comb begin
    for (int r = 0; r < MK; r++) begin
      new_col[r] = '0;
      if (KW'(r) + KW'(1) == kcfg) new_col[r] = pix_in;
      else if (KW'(r) + KW'(1) < kcfg) new_col[r] = line_rd[LW'(kcfg - KW'(r) - KW'(2))];
    end
  end

  always_comb begin
    for (int r = 0; r < MK; r++) begin
      for (int c = 0; c < MK; c++) begin
        win_nxt[r][c] = '0;
        if (KW'(c) + KW'(1) == kcfg) win_nxt[r][c] = new_col[r];
      end
      for (int c = 0; c < MK - 1; c++) begin
        if (KW'(c) + KW'(1) < kcfg) win_nxt[r][c] = win[r][c + 1];
      end
    end
  end

  always_comb begin
    for (int r = 0; r < MK; r++) begin
      for (int c = 0; c < MK; c++) patch_out[(r*MK + c)*NUM_CH +: NUM_CH] = win[r][c];
    end
  end

  // Line memories are never read before being written within a frame, so no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      line_mem[0][col] <= pix_in;
      for (int i = 1; i < NL; i++) line_mem[i][col] <= line_mem[i-1][col];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      wcfg        <= '0;
      hcfg        <= '0;
      kcfg        <= '0;
      scfg        <= '0;
      col         <= '0;
      row         <= '0;
      cph         <= '0;
      rph         <= '0;
      win         <= '{default: '0};
      patch_valid <= 1'b0;
      patch_x     <= '0;
      patch_y     <= '0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      cfg_err    <= 1'b0;
      if (patch_valid && patch_ready) patch_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (cfg_ok) begin
              wcfg  <= img_width;
              hcfg  <= img_height;
              kcfg  <= kernel_size;
              scfg  <= stride;
              col   <= '0;
              row   <= '0;
              cph   <= '0;
              rph   <= '0;
              win   <= '{default: '0};
              busy  <= 1'b1;
              state <= STREAM;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        STREAM: begin
          if (accept) begin
            win <= win_nxt;
            if (emit) begin
              patch_valid <= 1'b1;
              patch_x     <= XW'(CW'(col) + CW'(1) - CW'(kcfg));
              patch_y     <= YW'(RW'(row) + RW'(1) - RW'(kcfg));
            end
            if (col_last) begin
              col <= '0;
              cph <= '0;
              if (row_last) begin
                state <= DRAIN;
              end else begin
                row <= row + YW'(1);
                rph <= row_in ? ph_step(rph, scfg) : 2'd0;
              end
            end else begin
              col <= col + XW'(1);
              cph <= col_in ? ph_step(cph, scfg) : 2'd0;
            end
          end
        end
        DRAIN: begin
          if (!patch_valid || patch_ready) begin
            state      <= DONE;
            frame_done <= 1'b1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_window_buffer.sv
// Bench for conv_window_buffer: table of frame configurations checked against a patch model,
// plus hand sequences for reset-time outputs and a reset that abandons a frame.
module tb_conv_window_buffer;

  localparam int BW = 34;
  localparam int BH = 34;
  localparam int MK = 7;
  localparam int NC = 2;
  localparam int PW = MK*MK*NC;
  localparam int WW = $clog2(BW+1);
  localparam int HW = $clog2(BH+1);
  localparam int KW = $clog2(MK+1);
  localparam int XW = $clog2(BW);
  localparam int YW = $clog2(BH);
  localparam int NVEC = 13;

  typedef struct {
    int w; int h; int k; int s;
    bit rnd; bit stall; bit err;
    int npatch; int poke;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [WW-1:0] img_width = '0;
  logic [HW-1:0] img_height = '0;
  logic [KW-1:0] kernel_size = '0;
  logic [1:0]    stride = '0;
  logic [NC-1:0] pix_in = '0;
  logic          pix_valid = 1'b0;
  logic          pix_ready;
  logic [PW-1:0] patch_out;
  logic          patch_valid;
  logic          patch_ready = 1'b1;
  logic [XW-1:0] patch_x;
  logic [YW-1:0] patch_y;
  logic          busy;
  logic          frame_done;
  logic          cfg_err;

  int            nvec = 0;
  int            nerr = 0;
  logic [NC-1:0] img [BH][BW];
  int            eq_x[$];
  int            eq_y[$];
  logic [PW-1:0] ck;
  vec_t          tbl [NVEC];
  vec_t          ab;
  int            nd;

  always #5 clk = ~clk;

  conv_window_buffer #(
    .BUF_WIDTH(BW), .BUF_HEIGHT(BH), .MAX_KERNEL_SIZE(MK), .NUM_CH(NC)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .img_width(img_width), .img_height(img_height), .kernel_size(kernel_size), .stride(stride),
    .pix_in(pix_in), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .patch_out(patch_out), .patch_valid(patch_valid), .patch_ready(patch_ready),
    .patch_x(patch_x), .patch_y(patch_y),
    .busy(busy), .frame_done(frame_done), .cfg_err(cfg_err)
  );

  task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] model_patch(input int x, input int y, input int k);
    logic [PW-1:0] p = '0;
    for (int r = 0; r < k; r++)
      for (int c = 0; c < k; c++)
        p[(r*MK + c)*NC +: NC] = img[y+r][x+c];
    return p;
  endfunction

  task automatic run_frame(input vec_t v, input int abort_at);
    int acc = 0, got = 0, last_acc = -10, last_hs = -10, done_it = -1;
    int bubbles = 0, late = 0, exp_done, total, budget;
    bit saw_err = 1'b0, done = 1'b0;
    total  = v.w * v.h;
    budget = total * 8 + 100;
    eq_x.delete();
    eq_y.delete();
    if (!v.err) begin
      for (int y = 0; y < v.h; y++)
        for (int x = 0; x < v.w; x++)
          img[y][x] = v.rnd ? NC'($urandom) : {NC{1'((x + y) & 1)}};
      for (int y = 0; y + v.k <= v.h; y += v.s)
        for (int x = 0; x + v.k <= v.w; x += v.s) begin
          eq_x.push_back(x);
          eq_y.push_back(y);
        end
    end

    @(negedge clk);
    img_width   = WW'(v.w);
    img_height  = HW'(v.h);
    kernel_size = KW'(v.k);
    stride      = 2'(v.s);
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (v.err) begin
      check("cfg_err_pulse", PW'(cfg_err), PW'(1));
      check("err_busy", PW'(busy), '0);
      check("err_pix_ready", PW'(pix_ready), '0);
      @(negedge clk);
      check("cfg_err_clear", PW'(cfg_err), '0);
      check("err_busy_after", PW'(busy), '0);
      return;
    end
    check("start_busy", PW'(busy), PW'(1));

    for (int it = 0; it < budget && !done; it++) begin
      if (it > 0) @(negedge clk);
      if (acc == abort_at) return;
      start       = (it == v.poke);
      kernel_size = (it == v.poke) ? KW'(2) : KW'(v.k);
      patch_ready = v.stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      pix_valid   = (acc < total) && (v.stall ? ($urandom_range(0, 4) != 0) : 1'b1);
      if (acc < total) pix_in = img[acc / v.w][acc % v.w];
      #1;
      if (cfg_err) saw_err = 1'b1;
      if (frame_done) begin
        done    = 1'b1;
        done_it = it;
      end
      if (patch_valid && eq_x.size() > 0) begin
        check("patch_out", patch_out, model_patch(eq_x[0], eq_y[0], v.k));
        check("patch_x", PW'(patch_x), PW'(eq_x[0]));
        check("patch_y", PW'(patch_y), PW'(eq_y[0]));
        if (!v.rnd && v.k == 3 && eq_x[0] == 1 && eq_y[0] == 1) check("checker_1_1", patch_out, ck);
      end
      if (patch_valid && patch_ready) begin
        got++;
        last_hs = it;
        if (eq_x.size() > 0) begin
          void'(eq_x.pop_front());
          void'(eq_y.pop_front());
        end
      end
      if (patch_valid && !patch_ready) check("stall_pix_ready", PW'(pix_ready), '0);
      if (acc < total && !v.stall && !pix_ready) bubbles++;
      if (acc >= total && pix_ready) late++;
      if (pix_valid && pix_ready) begin
        acc++;
        last_acc = it;
      end
    end

    exp_done = (last_acc + 2 > last_hs + 1) ? last_acc + 2 : last_hs + 1;
    check("frame_done_seen", PW'(done), PW'(1));
    check("patch_count", PW'(got), PW'(v.npatch));
    check("frame_done_cycle", PW'(done_it), PW'(exp_done));
    check("drain_pix_ready", PW'(late), '0);
    if (!v.stall) check("bubbles", PW'(bubbles), '0);
    check("start_ignored", PW'(saw_err), '0);
    @(negedge clk);
    check("idle_busy", PW'(busy), '0);
    check("done_pulse", PW'(frame_done), '0);
  endtask

  initial begin
    //             w   h  k  s  rnd   stall err   n    poke
    tbl[0]  = '{  5,  5, 3, 1, 1'b0, 1'b0, 1'b0,   9, -1};
    tbl[1]  = '{  6,  6, 2, 2, 1'b1, 1'b1, 1'b0,   9, -1};
    tbl[2]  = '{  3,  5, 4, 1, 1'b0, 1'b0, 1'b1,   0, -1};
    tbl[3]  = '{ 34, 34, 7, 1, 1'b1, 1'b0, 1'b0, 784, -1};
    tbl[4]  = '{  4,  4, 3, 1, 1'b1, 1'b1, 1'b0,   4, -1};
    tbl[5]  = '{  7,  5, 1, 3, 1'b1, 1'b1, 1'b0,   6, -1};
    tbl[6]  = '{  8,  6, 3, 3, 1'b1, 1'b0, 1'b0,   4, 10};
    tbl[7]  = '{  3,  3, 3, 2, 1'b1, 1'b1, 1'b0,   1, -1};
    tbl[8]  = '{ 34,  3, 2, 1, 1'b1, 1'b0, 1'b0,  66, -1};
    tbl[9]  = '{ 10, 10, 0, 1, 1'b0, 1'b0, 1'b1,   0, -1};
    tbl[10] = '{ 10, 10, 3, 0, 1'b0, 1'b0, 1'b1,   0, -1};
    tbl[11] = '{ 35, 10, 3, 1, 1'b0, 1'b0, 1'b1,   0, -1};
    tbl[12] = '{ 10,  2, 3, 1, 1'b0, 1'b0, 1'b1,   0, -1};

    // 3x3 checkerboard starting at 0, both channels: set where r+c is odd.
    ck = '0;
    ck[3:2]   = 2'b11;
    ck[15:14] = 2'b11;
    ck[19:18] = 2'b11;
    ck[31:30] = 2'b11;

    repeat (2) @(negedge clk);
    check("rst_patch_valid", PW'(patch_valid), '0);
    check("rst_patch_out", patch_out, '0);
    check("rst_busy", PW'(busy), '0);
    check("rst_pix_ready", PW'(pix_ready), '0);
    check("rst_frame_done", PW'(frame_done), '0);
    check("rst_cfg_err", PW'(cfg_err), '0);
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++) run_frame(tbl[i], -1);

    // Reset abandons a frame with patch (0,1) pending after pixel (2,3).
    ab = '{5, 5, 3, 1, 1'b1, 1'b0, 1'b0, 9, -1};
    run_frame(ab, 18);
    check("abort_pending", PW'(patch_valid), PW'(1));
    check("abort_y", PW'(patch_y), PW'(1));
    pix_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_patch_valid", PW'(patch_valid), '0);
    check("mid_rst_patch_out", patch_out, '0);
    check("mid_rst_patch_x", PW'(patch_x), '0);
    check("mid_rst_patch_y", PW'(patch_y), '0);
    check("mid_rst_busy", PW'(busy), '0);
    check("mid_rst_pix_ready", PW'(pix_ready), '0);
    check("mid_rst_frame_done", PW'(frame_done), '0);
    check("mid_rst_cfg_err", PW'(cfg_err), '0);
    nd = 0;
    repeat (8) begin
      @(negedge clk);
      if (frame_done || busy) nd++;
    end
    check("no_done_after_rst", PW'(nd), '0);
    ab = '{4, 4, 3, 1, 1'b1, 1'b0, 1'b0, 4, -1};
    run_frame(ab, -1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors applied", nvec);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/conv_window_buffer.md
Name: conv_window_buffer

Overview:
- Parametrised successor to the single-kernel bit-column shift buffer. Sits between the booleanised-image input stream and the clause/patch evaluation array of the ConvCoTM accelerator.
- Accepts binary multi-channel pixels in raster order and stores MAX_KERNEL_SIZE-1 image lines internally.
- Emits complete KxK patches, with K, stride and image size set at runtime, plus patch coordinates.
- Uses valid/ready handshakes on input and output with backpressure.

Parameters:
- BUF_WIDTH, 34, maximum image width in pixels (line-memory depth).
- BUF_HEIGHT, 34, maximum image height in pixels.
- MAX_KERNEL_SIZE, 7, largest supported kernel edge K.
- NUM_CH, 1, binary channels per pixel.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  pulse: latch config and begin a frame.
- img_width  in  $clog2(BUF_WIDTH+1)  image width W.
- img_height  in  $clog2(BUF_HEIGHT+1)  image height H.
- kernel_size  in  $clog2(MAX_KERNEL_SIZE+1)  K.
- stride  in  2  patch stride S, legal values 1..3.
- pix_in  in  NUM_CH  pixel data.
- pix_valid  in  1  pixel valid.
- pix_ready  out  1  pixel accepted when valid&&ready.
- patch_out  out  MAX_KERNEL_SIZE*MAX_KERNEL_SIZE*NUM_CH  window; bit index ((r*MAX_KERNEL_SIZE+c)*NUM_CH+ch), r=0 is the top row, c=0 is the leftmost column.
- patch_valid  out  1  patch available.
- patch_ready  in  1  consumer accepts.
- patch_x  out  $clog2(BUF_WIDTH)  left column of the patch.
- patch_y  out  $clog2(BUF_HEIGHT)  top row of the patch.
- busy  out  1  frame in progress.
- frame_done  out  1  one-cycle pulse at end of frame.
- cfg_err  out  1  one-cycle pulse on rejected start.

Behaviour:
- Reset (clk edge with rst=1): every output is 0, including patch_out. The FSM goes to IDLE, all counters and the window register are cleared. Line-memory contents are not reset; they are never observed before being rewritten. Reset mid-frame abandons the frame, and no frame_done is issued.
- FSM states are IDLE, STREAM, DRAIN and DONE.
- IDLE: on start, check the config.
  - Legal config: 1<=K<=MAX_KERNEL_SIZE, K<=W<=BUF_WIDTH, K<=H<=BUF_HEIGHT, 1<=S<=3. Latch W, H, K, S, clear col/row to 0, go to STREAM, busy=1 the next cycle.
  - Illegal config: pulse cfg_err the next cycle and stay in IDLE.
- start is ignored outside IDLE.
- pix_ready = (state==STREAM) && (!patch_valid || patch_ready). There is no skid buffer.
- On each accepted pixel at (col,row):
  - The window shifts one column left.
  - The new rightmost column is {line_mem[K-2..0][col], pix_in}, with the current pixel at row K-1.
  - The line memories shift vertically at column col.
  - Window rows and columns >= K read as 0 in patch_out.
- Emit condition: col>=K-1, row>=K-1, (col-K+1)%S==0 and (row-K+1)%S==0.
  - The cycle after such an accept: patch_valid=1, patch_x=col-K+1, patch_y=row-K+1.
  - Latency is 1 cycle from the accepting edge.
- patch_valid, patch_out and the coordinates hold stable until patch_valid&&patch_ready. In the same cycle a new accept may reload them back-to-back, giving full throughput of one pixel per cycle.
- Counters: col wraps W-1 -> 0 and increments row. The window is not cleared on row wrap; the emit condition masks stale columns. Use width-safe compares only, with no negative intermediates (compare col+1>=K).
- After accepting (W-1,H-1), go to DRAIN and deassert pix_ready.
  - DRAIN waits until no patch is pending, then goes to DONE.
  - DONE pulses frame_done for one cycle, clears busy, and returns to IDLE.
  - If the last pixel emits a patch, frame_done follows that patch's handshake by 1 cycle.
- K=1 is a legal degenerate case: every pixel on the stride grid becomes a 1x1 patch.

Test Plan:
- W=5, H=5, K=3, S=1, pixel = (col+row)&1, patch_ready=1 tied high -> 9 patches, coordinates (0,0)…(2,2) in raster order. Patch (1,1) equals the checkerboard pattern starting at 0. frame_done occurs 2 cycles after the last accept.
- W=6, H=6, K=2, S=2, with random patch_ready stalls -> exactly 9 patches at even coordinates. patch_out and patch_x/patch_y stay stable while stalled, and pix_ready=0 while the patch is pending and stalled.
- start with K=4, W=3 -> cfg_err pulse, busy stays 0, pix_ready stays 0.
- K=MAX_KERNEL_SIZE=7, W=H=BUF_WIDTH=34, NUM_CH=2, random pixels compared against a golden model -> 784 patches, all bits match, and no bubbles when ready is held high.
- K=3 full frame, then rst asserted for one cycle mid-row 3 -> all outputs 0, no frame_done. A new start with W=H=4, K=3 gives 4 correct patches.
- start asserted during STREAM -> ignored, and the frame completes normally.
